// File: rtl/exec_sched_pkg.sv
// ---------------------------------------------------------------------------
// exec_sched_pkg
// Shared types and constants for the executor job scheduler:
//   - scheduler state encoding
//   - error codes reported on the status interface
//   - job descriptor layout (16-bit buffer address + 8-bit tag)
// ---------------------------------------------------------------------------
package exec_sched_pkg;

  localparam int ADDR_W = 16;
  localparam int TAG_W  = 8;
  localparam int ERR_W  = 8;
  localparam int CNT_W  = 16;
  localparam int DESC_W = ADDR_W + TAG_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_COLLECT = 3'd3,
    ST_ABORT   = 3'd4,
    ST_FLUSH   = 3'd5
  } sched_state_e;

  // Status error codes. ERR_BAD_OPCODE is raised by the executor itself and
  // only passes through this block inside exec_error.
  localparam logic [ERR_W-1:0] ERR_NONE       = 8'h00;
  localparam logic [ERR_W-1:0] ERR_BAD_OPCODE = 8'h81;
  localparam logic [ERR_W-1:0] ERR_HOST_ABORT = 8'h82;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT    = 8'h83;
  localparam logic [ERR_W-1:0] ERR_FLUSHED    = 8'h84;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
  } desc_t;

  function automatic logic [DESC_W-1:0] pack_desc(input logic [ADDR_W-1:0] addr,
                                                  input logic [TAG_W-1:0]  tag);
    return {addr, tag};
  endfunction

endpackage

// File: rtl/exec_scheduler_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock descriptor queue with a first-word-fall-through head output.
//   clk, rst_n   : clock, asynchronous active-low reset (clears pointers)
//   push_i/push_data_i : write request and data; dropped while full
//   pop_i        : remove head entry; ignored while empty
//   head_o       : current head entry (valid while !empty_o)
//   full_o, empty_o : occupancy flags
// DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only observed after it was written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/exec_scheduler.sv
// ---------------------------------------------------------------------------
// exec_scheduler
// Queues job descriptors and runs them one at a time on the command-buffer
// executor: start pulse, wait for completion (with watchdog), collect the
// executor error byte and report one status pulse per job.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   desc_addr_i/desc_tag_i/desc_valid_i, desc_ready_o : descriptor push
//   halt_on_err_i         : stop dequeuing after a failing job
//   resume_i              : clears the halted flag
//   host_abort_i          : abort current job and flush the queue
//   timeout_i             : watchdog limit in cycles, 0 disables
//   exec_start_o/exec_start_addr_o/exec_abort_o : executor control
//   exec_complete_i/exec_error_i : executor completion, error byte a cycle later
//   status_valid_o/status_tag_o/status_error_o : per-job report
//   busy_o, halted_o, jobs_done_o, jobs_failed_o : status/counters
// ---------------------------------------------------------------------------
module exec_scheduler
  import exec_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_W  = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    desc_addr_i,
  input  logic [TAG_W-1:0]     desc_tag_i,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  input  logic                 halt_on_err_i,
  input  logic                 resume_i,
  input  logic                 host_abort_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic                 exec_start_o,
  output logic [ADDR_W-1:0]    exec_start_addr_o,
  output logic                 exec_abort_o,
  input  logic                 exec_complete_i,
  input  logic [ERR_W-1:0]     exec_error_i,
  output logic                 status_valid_o,
  output logic [TAG_W-1:0]     status_tag_o,
  output logic [ERR_W-1:0]     status_error_o,
  output logic                 busy_o,
  output logic                 halted_o,
  output logic [CNT_W-1:0]     jobs_done_o,
  output logic [CNT_W-1:0]     jobs_failed_o
);

  localparam logic [TIMEOUT_W-1:0] TMO_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  sched_state_e         state_q, state_d;
  logic [TAG_W-1:0]     cur_tag_q, cur_tag_d;
  logic [ADDR_W-1:0]    cur_addr_q, cur_addr_d;
  logic                 host_cause_q, host_cause_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 exec_start_q, exec_start_d;
  logic [ADDR_W-1:0]    exec_start_addr_q, exec_start_addr_d;
  logic                 exec_abort_q, exec_abort_d;
  logic                 status_valid_q, status_valid_d;
  logic [TAG_W-1:0]     status_tag_q, status_tag_d;
  logic [ERR_W-1:0]     status_error_q, status_error_d;
  logic [CNT_W-1:0]     jobs_done_q, jobs_done_d;
  logic [CNT_W-1:0]     jobs_failed_q, jobs_failed_d;
  logic                 halted_q, halted_d;

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DESC_W-1:0]    fifo_head;
  desc_t                head_desc;
  logic                 abort_req;
  logic [ERR_W-1:0]     abort_code;

  sync_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (desc_valid_i),
    .push_data_i (pack_desc(desc_addr_i, desc_tag_i)),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign head_desc = fifo_head;

  always_comb begin
    state_d           = state_q;
    cur_tag_d         = cur_tag_q;
    cur_addr_d        = cur_addr_q;
    host_cause_d      = host_cause_q;
    wdog_d            = wdog_q;
    exec_start_d      = 1'b0;
    exec_start_addr_d = exec_start_addr_q;
    exec_abort_d      = 1'b0;
    status_valid_d    = 1'b0;
    status_tag_d      = status_tag_q;
    status_error_d    = status_error_q;
    jobs_done_d       = jobs_done_q;
    jobs_failed_d     = jobs_failed_q;
    halted_d          = halted_q;
    fifo_pop          = 1'b0;
    abort_req         = 1'b0;
    abort_code        = ERR_HOST_ABORT;

    // Resume is applied first so a halt raised in COLLECT this cycle wins.
    if (resume_i) halted_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (host_abort_i) begin
          state_d = ST_FLUSH;
        end else if (!fifo_empty && !halted_q) begin
          fifo_pop   = 1'b1;
          cur_tag_d  = head_desc.tag;
          cur_addr_d = head_desc.addr;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        // An abort here still pulses exec_abort; harmless for an idle executor.
        if (host_abort_i) begin
          abort_req = 1'b1;
        end else begin
          exec_start_d      = 1'b1;
          exec_start_addr_d = cur_addr_q;
          wdog_d            = '0;
          state_d           = ST_RUN;
        end
      end

      ST_RUN: begin
        wdog_d = wdog_q + TMO_ONE;
        if (host_abort_i) begin
          abort_req = 1'b1;
        end else if (exec_complete_i) begin
          state_d = ST_COLLECT;
        end else if ((timeout_i != '0) && (wdog_q == timeout_i - TMO_ONE)) begin
          abort_req  = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end

      ST_COLLECT: begin
        status_valid_d = 1'b1;
        status_tag_d   = cur_tag_q;
        status_error_d = exec_error_i;
        if (exec_error_i == ERR_NONE) begin
          jobs_done_d = jobs_done_q + CNT_ONE;
        end else begin
          jobs_failed_d = jobs_failed_q + CNT_ONE;
          if (halt_on_err_i) halted_d = 1'b1;
        end
        // The job already finished normally, so a host abort arriving now
        // reports this job as collected and goes straight to flushing.
        state_d = host_abort_i ? ST_FLUSH : ST_IDLE;
      end

      ST_ABORT: begin
        state_d = host_cause_q ? ST_FLUSH : ST_IDLE;
      end

      ST_FLUSH: begin
        if (!fifo_empty) begin
          fifo_pop       = 1'b1;
          status_valid_d = 1'b1;
          status_tag_d   = head_desc.tag;
          status_error_d = ERR_FLUSHED;
          jobs_failed_d  = jobs_failed_q + CNT_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort pulse and its status are registered on entry to ABORT, so they
    // are visible during the ABORT cycle itself.
    if (abort_req) begin
      state_d        = ST_ABORT;
      exec_abort_d   = 1'b1;
      status_valid_d = 1'b1;
      status_tag_d   = cur_tag_q;
      status_error_d = abort_code;
      jobs_failed_d  = jobs_failed_q + CNT_ONE;
      host_cause_d   = (abort_code == ERR_HOST_ABORT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      cur_tag_q         <= '0;
      cur_addr_q        <= '0;
      host_cause_q      <= 1'b0;
      wdog_q            <= '0;
      exec_start_q      <= 1'b0;
      exec_start_addr_q <= '0;
      exec_abort_q      <= 1'b0;
      status_valid_q    <= 1'b0;
      status_tag_q      <= '0;
      status_error_q    <= '0;
      jobs_done_q       <= '0;
      jobs_failed_q     <= '0;
      halted_q          <= 1'b0;
    end else begin
      state_q           <= state_d;
      cur_tag_q         <= cur_tag_d;
      cur_addr_q        <= cur_addr_d;
      host_cause_q      <= host_cause_d;
      wdog_q            <= wdog_d;
      exec_start_q      <= exec_start_d;
      exec_start_addr_q <= exec_start_addr_d;
      exec_abort_q      <= exec_abort_d;
      status_valid_q    <= status_valid_d;
      status_tag_q      <= status_tag_d;
      status_error_q    <= status_error_d;
      jobs_done_q       <= jobs_done_d;
      jobs_failed_q     <= jobs_failed_d;
      halted_q          <= halted_d;
    end
  end

  assign desc_ready_o      = !fifo_full;
  assign exec_start_o      = exec_start_q;
  assign exec_start_addr_o = exec_start_addr_q;
  assign exec_abort_o      = exec_abort_q;
  assign status_valid_o    = status_valid_q;
  assign status_tag_o      = status_tag_q;
  assign status_error_o    = status_error_q;
  assign busy_o            = (state_q != ST_IDLE) || !fifo_empty;
  assign halted_o          = halted_q;
  assign jobs_done_o       = jobs_done_q;
  assign jobs_failed_o     = jobs_failed_q;

endmodule

// File: tb/tb_exec_scheduler.sv
// ---------------------------------------------------------------------------
// tb_exec_scheduler
// Drives descriptor pushes and an executor model; every job's outcome is
// predicted from its planned latency/error and the scheduler rules, and the
// status stream, counters and pulses are checked against that prediction.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_exec_scheduler;

  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   desc_addr;
  logic [7:0]    desc_tag;
  logic          desc_valid;
  logic          desc_ready;
  logic          halt_on_err;
  logic          resume;
  logic          host_abort;
  logic [TW-1:0] timeout;
  logic          exec_start;
  logic [15:0]   exec_start_addr;
  logic          exec_abort;
  logic          exec_complete;
  logic [7:0]    exec_error;
  logic          status_valid;
  logic [7:0]    status_tag;
  logic [7:0]    status_error;
  logic          busy;
  logic          halted;
  logic [15:0]   jobs_done;
  logic [15:0]   jobs_failed;

  exec_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_W(TW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .desc_addr_i       (desc_addr),
    .desc_tag_i        (desc_tag),
    .desc_valid_i      (desc_valid),
    .desc_ready_o      (desc_ready),
    .halt_on_err_i     (halt_on_err),
    .resume_i          (resume),
    .host_abort_i      (host_abort),
    .timeout_i         (timeout),
    .exec_start_o      (exec_start),
    .exec_start_addr_o (exec_start_addr),
    .exec_abort_o      (exec_abort),
    .exec_complete_i   (exec_complete),
    .exec_error_i      (exec_error),
    .status_valid_o    (status_valid),
    .status_tag_o      (status_tag),
    .status_error_o    (status_error),
    .busy_o            (busy),
    .halted_o          (halted),
    .jobs_done_o       (jobs_done),
    .jobs_failed_o     (jobs_failed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [15:0] addr; logic [7:0] tag; } job_t;
  typedef struct { logic [7:0] tag; logic [7:0] err; } stat_t;

  job_t       model_q[$];     // jobs accepted but not yet started
  stat_t      exp_q[$];       // status reports predicted, not yet seen
  int         plan_lat [256]; // executor latency per tag, 0 = never completes
  logic [7:0] plan_err [256];

  int         cd = 0;
  bit         err_pend = 0;
  logic [7:0] pend_err;
  logic [7:0] cur_tag = '0;
  int         start_cyc = 0;
  int         n_starts = 0;
  int         n_aborts = 0;
  logic [15:0] m_done = '0;
  logic [15:0] m_failed = '0;
  bit         model_halted = 0;
  bit         host_pend = 0;
  bit         prev_start = 0;

  // Executor model and output monitor, all at the falling edge.
  initial begin
    job_t  j;
    stat_t s;
    exec_complete = 1'b0;
    exec_error    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exec_complete = 1'b0;
        prev_start    = 0;
      end else begin
        exec_complete = 1'b0;
        if (err_pend) begin
          exec_error = pend_err;
          err_pend   = 0;
        end else begin
          exec_error = 8'($urandom);
        end
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            exec_complete = 1'b1;
            err_pend      = 1;
            pend_err      = plan_err[cur_tag];
            s.tag = cur_tag;
            s.err = plan_err[cur_tag];
            exp_q.push_back(s);
            if (plan_err[cur_tag] != 0 && halt_on_err) model_halted = 1;
          end
        end

        if (exec_start) begin
          check_val("start_width", prev_start, 0);
          check_val("start_while_halted", model_halted, 0);
          check_val("start_has_job", model_q.size() != 0, 1);
          if (model_q.size() != 0) begin
            j = model_q.pop_front();
            check_val("start_addr", exec_start_addr, j.addr);
            cur_tag   = j.tag;
            start_cyc = cyc;
            cd        = plan_lat[j.tag];
          end
          n_starts++;
        end

        if (exec_abort) begin
          n_aborts++;
          cd = 0;
          s.tag = cur_tag;
          if (host_pend) begin
            s.err = 8'h82;
            exp_q.push_back(s);
            while (model_q.size() != 0) begin
              j = model_q.pop_front();
              s.tag = j.tag;
              s.err = 8'h84;
              exp_q.push_back(s);
            end
            host_pend = 0;
          end else begin
            check_val("abort_was_hang", plan_lat[cur_tag], 0);
            check_val("wdog_abort_cycle", cyc - start_cyc, 32'(timeout));
            s.err = 8'h83;
            exp_q.push_back(s);
          end
        end

        if (status_valid) begin
          check_val("status_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            s = exp_q.pop_front();
            if (s.err == 0) m_done++;
            else            m_failed++;
            check_val("status_tag", status_tag, s.tag);
            check_val("status_error", status_error, s.err);
            check_val("jobs_done", jobs_done, m_done);
            check_val("jobs_failed", jobs_failed, m_failed);
            check_val("halted_at_status", halted, model_halted);
          end
          $display("status tag=%02h err=%02h done=%0d failed=%0d halted=%0d",
                   status_tag, status_error, jobs_done, jobs_failed, halted);
        end
        prev_start = exec_start;
      end
    end
  end

  task automatic push_job(input logic [15:0] a, input logic [7:0] t, input int lat,
                          input logic [7:0] e, output bit acc);
    job_t j;
    plan_lat[t] = lat;
    plan_err[t] = e;
    desc_addr   = a;
    desc_tag    = t;
    desc_valid  = 1'b1;
    acc         = desc_ready;
    if (acc) begin
      j.addr = a;
      j.tag  = t;
      model_q.push_back(j);
    end
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_idle"}, busy, 0);
    repeat (2) @(negedge clk);
    check_val({tag, "_pending_status"}, exp_q.size(), 0);
    check_val({tag, "_pending_jobs"}, model_q.size(), 0);
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (n_starts < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_started"}, n_starts >= target, 1);
  endtask

  task automatic pulse_resume();
    model_halted = 0;
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
  endtask

  initial begin
    bit          acc;
    int          base_s, base_a;
    logic [15:0] base_f, base_d;
    int          push_cyc;
    logic [7:0]  next_tag;
    int          n;
    stat_t       s;
    job_t        j;

    rst_n = 1'b0;
    desc_addr = '0; desc_tag = '0; desc_valid = 1'b0;
    halt_on_err = 1'b0; resume = 1'b0; host_abort = 1'b0; timeout = '0;

    // Reset state
    #12;
    check_val("rst_exec_start", exec_start, 0);
    check_val("rst_status_valid", status_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_jobs_done", jobs_done, 0);
    @(negedge clk); #3 rst_n = 1'b1;
    @(negedge clk);

    // Single job, watchdog disabled: start latency and basic report
    push_cyc = cyc;
    push_job(16'h0010, 8'hA1, 5, 8'h00, acc);
    check_val("t1_accept", acc, 1);
    wait_idle(100, "t1");
    check_val("t1_start_latency", start_cyc, push_cyc + 3);
    check_val("t1_jobs_done", jobs_done, 1);

    // Fill the queue behind a running job; fifth push is dropped
    base_d = jobs_done;
    base_s = n_starts;
    push_job(16'h0100, 8'hB0, 8, 8'h00, acc);
    wait_starts(base_s + 1, 20, "t2");
    for (int i = 1; i <= 4; i++) begin
      push_job(16'h0100 + 16'(i), 8'hB0 + 8'(i), 2 + i, 8'h00, acc);
      check_val("t2_accept", acc, 1);
    end
    check_val("t2_ready_full", desc_ready, 0);
    push_job(16'h0105, 8'hB5, 1, 8'h00, acc);
    check_val("t2_fifth_dropped", acc, 0);
    wait_idle(200, "t2");
    check_val("t2_jobs_done_delta", jobs_done - base_d, 5);

    // Watchdog abort, then the queued job runs
    timeout = 24'd20;
    base_s = n_starts;
    base_a = n_aborts;
    push_job(16'h0C30, 8'hC3, 0, 8'h00, acc);
    push_job(16'h0C40, 8'hC4, 4, 8'h00, acc);
    wait_idle(200, "t3");
    check_val("t3_aborts", n_aborts - base_a, 1);
    check_val("t3_starts", n_starts - base_s, 2);
    timeout = '0;

    // Halt on error, resume
    halt_on_err = 1'b1;
    base_s = n_starts;
    push_job(16'h0510, 8'h51, 3, 8'h05, acc);
    push_job(16'h0520, 8'h52, 3, 8'h00, acc);
    repeat (20) @(negedge clk);
    check_val("t4_halted", halted, 1);
    check_val("t4_no_second_start", n_starts - base_s, 1);
    check_val("t4_busy_halted", busy, 1);
    pulse_resume();
    wait_idle(100, "t4");
    check_val("t4_resumed_start", n_starts - base_s, 2);
    check_val("t4_halted_cleared", halted, 0);

    // Halted with jobs queued, host abort from IDLE flushes them
    base_a = n_aborts;
    push_job(16'h0530, 8'h53, 2, 8'h07, acc);
    push_job(16'h0540, 8'h54, 2, 8'h00, acc);
    push_job(16'h0550, 8'h55, 2, 8'h00, acc);
    repeat (20) @(negedge clk);
    check_val("t4b_halted", halted, 1);
    while (model_q.size() != 0) begin
      j = model_q.pop_front();
      s.tag = j.tag;
      s.err = 8'h84;
      exp_q.push_back(s);
    end
    host_abort = 1'b1;
    @(negedge clk);
    host_abort = 1'b0;
    wait_idle(50, "t4b");
    check_val("t4b_no_exec_abort", n_aborts - base_a, 0);
    check_val("t4b_still_halted", halted, 1);
    halt_on_err = 1'b0;
    pulse_resume();
    @(negedge clk);
    check_val("t4b_resume", halted, 0);

    // Host abort during RUN of a hung job with two queued behind it
    base_f = jobs_failed;
    base_s = n_starts;
    base_a = n_aborts;
    push_job(16'h0D10, 8'hD1, 0, 8'h00, acc);
    push_job(16'h0D20, 8'hD2, 3, 8'h00, acc);
    push_job(16'h0D30, 8'hD3, 3, 8'h00, acc);
    wait_starts(base_s + 1, 20, "t5");
    repeat (30) @(negedge clk);
    host_pend  = 1;
    host_abort = 1'b1;
    @(negedge clk);
    host_abort = 1'b0;
    wait_idle(50, "t5");
    check_val("t5_exec_abort", n_aborts - base_a, 1);
    check_val("t5_failed_delta", jobs_failed - base_f, 3);

    // Randomized traffic with watchdog enabled
    timeout  = 24'd12;
    next_tag = 8'h60;
    for (int g = 0; g < 12; g++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        push_job(16'($urandom), next_tag,
                 ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 8),
                 ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)), acc);
        next_tag++;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle(400, "rnd");
    end
    timeout = '0;

    // Asynchronous reset in the middle of a running job
    push_job(16'hE100, 8'hE1, 0, 8'h00, acc);
    wait_starts(n_starts + 1, 20, "t6");
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    model_q.delete();
    exp_q.delete();
    cd = 0; err_pend = 0; m_done = '0; m_failed = '0; model_halted = 0;
    #1;
    check_val("arst_exec_start", exec_start, 0);
    check_val("arst_exec_start_addr", exec_start_addr, 0);
    check_val("arst_exec_abort", exec_abort, 0);
    check_val("arst_status_valid", status_valid, 0);
    check_val("arst_status_tag", status_tag, 0);
    check_val("arst_status_error", status_error, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_halted", halted, 0);
    check_val("arst_jobs_done", jobs_done, 0);
    check_val("arst_jobs_failed", jobs_failed, 0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    base_s = n_starts;
    repeat (10) @(negedge clk);
    check_val("t6_no_start_after_reset", n_starts - base_s, 0);
    check_val("t6_idle_after_reset", busy, 0);
    push_job(16'hE200, 8'hE2, 2, 8'h00, acc);
    wait_idle(50, "t6");
    check_val("t6_jobs_done", jobs_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
